// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: 1 start bit, DBIT data bits LSB first, SB_TICK/16 stop bits.
// Expects a one-clk s_tick at 16x baud; reports each frame with a one-cycle rx_done_tick.
module uart_rx_os #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            ferr_q, ferr_d;
    logic            done_q, done_d;
    logic            sync1_q, sync2_q;
    logic            rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Edge detection runs every clk so the start-bit phase is not quantised to ticks
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    // Framing errors still deliver the byte; the flag tells the consumer it is suspect
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign frame_err    = ferr_q;

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
16x-oversampling UART receiver. It is the consumer of the baud tick produced by the team's mod-M baud counter.
- Converts the serial rx line into parallel bytes: 1 start bit, DBIT data bits LSB first, 1 stop bit, no parity.
- Flags framing errors.
- Sits between the board rx pin and the command FIFO / host-interface logic.

Parameters:
DBIT, 8, number of data bits per frame (legal 5..8)
SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state
rx  input  1  serial line, idle high, asynchronous to clk
s_tick  input  1  one-clk-wide enable at 16x baud, from the baud counter's max_tick
rx_done_tick  output  1  one-cycle pulse; a frame has completed
dout  output  DBIT  last completed data byte; held until the next completion
frame_err  output  1  stop-bit value of the last frame was 0; valid with rx_done_tick, held until the next completion

Behaviour:
- Reset values: state=IDLE, s=0, n=0, shift reg b=0, dout=0, frame_err=0, rx_done_tick=0, synchronizer flops=1.
- Synchronizer: rx passes through 2 flops to give rx_s. The FSM uses only rx_s, which lags rx by 2 clk.
- Counters:
  - s: 0..SB_TICK-1, sized ceil(log2(max(16,SB_TICK))) bits.
  - n: 0..DBIT-1.
  - s and n change only on cycles with s_tick=1, except where noted below.
- FSM states: IDLE, START, DATA, STOP. Every state holds when s_tick=0, apart from the IDLE edge check.
- IDLE:
  - If rx_s==0 (checked every clk, no tick required): go to START with s=0.
- START:
  - On s_tick with s==7 (mid start bit): if rx_s==0, go to DATA with s=0, n=0; if rx_s==1 (glitch), return to IDLE with no output.
  - Otherwise on s_tick: s=s+1.
- DATA:
  - On s_tick with s==15: s=0 and b={rx_s, b[DBIT-1:1]}.
  - If n==DBIT-1, go to STOP; otherwise n=n+1.
  - Otherwise on s_tick: s=s+1.
- STOP:
  - On s_tick with s==SB_TICK-1: go to IDLE.
  - In the following cycle: rx_done_tick=1, dout=b, frame_err=~rx_s (rx_s as sampled at that tick).
  - Otherwise on s_tick: s=s+1.
- Outputs are registered, and rx_done_tick is high for exactly one clk.
- Error handling: a framing error still completes the frame (dout updated, frame_err=1). No resynchronisation on a break; a low line restarts START from IDLE.
- Back-to-back frames: a new start edge is accepted in the cycle after the STOP→IDLE transition. No dead time beyond that cycle.
- Reset mid-frame: asynchronous return to the reset values. No done pulse; the partial byte is discarded.
- s_tick held low: the FSM freezes (except the IDLE→START entry). No timeout.
- Simultaneous events: reset has priority over everything.

Test Plan:
1. s_tick=1 every clk (bit period 16 clk); send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) → exactly one rx_done_tick; dout=0xA5, frame_err=0; done asserts 8+8·16+16+1 clk after rx_s falls (±1), so first sampling is ≈2 clk after the rx edge.
2. s_tick every 4th clk; send 0x3C with stop bit driven 0 → rx_done_tick once, dout=0x3C, frame_err=1. Then send 0x5A normally → dout=0x5A, frame_err=0.
3. Glitch: rx low for 3 tick periods then high → FSM returns to IDLE, no rx_done_tick, dout unchanged.
4. Back-to-back frames 0x00 then 0xFF, no idle gap → two done pulses exactly 160 tick periods apart; dout=0x00 then 0xFF.
5. Assert reset in the middle of data bit 4 of 0x81 → all outputs 0 immediately; no done pulse. Then send 0x81 from idle → dout=0x81.
6. DBIT=7, SB_TICK=32; send 0x55 (7 bits) with 2 stop bits → dout=7'h55, frame_err=0, done after 8+7·16+32 ticks.
